zero_countdown_gen: RTL and testbench
=====================================

Name: zero_countdown_gen

Overview:
Loadable down-counter that drives an operand toward zero and reports when it gets there. It is the producer side of the team's zero-flag path: it generates COUNT and a registered zero flag Z (Z = 1 exactly when COUNT == 0). It also raises a DONE/ACK handshake so a controller can time loops or delays. It sits beside the datapath as a loop/delay counter feeding the zero-test logic.

Parameters:
WIDTH, 8, bit width of LOAD_VAL and COUNT.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-high reset.
START  input  1  load request; sampled only in IDLE, or in DONE together with ACK.
LOAD_VAL  input  WIDTH  start value; captured on the edge where START is accepted.
HOLD  input  1  pause; while 1 in RUN, COUNT does not change.
ACK  input  1  consumer acknowledges DONE.
COUNT  output  WIDTH  current counter value, registered.
Z  output  1  registered zero flag; 1 iff COUNT == 0.
BUSY  output  1  1 while in RUN.
DONE  output  1  1 while in DONE.

Behaviour:
- One clock, CLK. RST is asynchronous and active-high.
- While RST is high (immediately, with no clock edge needed):
  - state = IDLE
  - COUNT = 0, Z = 1, BUSY = 0, DONE = 0
  - After RST deasserts, the first active edge evaluates IDLE.
- Reset asserted mid-RUN or in DONE aborts the operation with no further DONE.
- FSM has three states: IDLE, RUN, DONE. All outputs are registered and decode directly from state/COUNT registers. No combinational input-to-output paths.
- IDLE:
  - START = 1: COUNT <= LOAD_VAL. If LOAD_VAL == 0, go to DONE; otherwise go to RUN.
  - START = 0: COUNT holds its value.
- RUN:
  - HOLD = 0: COUNT <= COUNT - 1. When COUNT == 1 on this edge, COUNT becomes 0 and state becomes DONE on the same edge.
  - HOLD = 1: COUNT and state both hold.
  - START is ignored. ACK is ignored.
- DONE:
  - COUNT stays 0. DONE = 1 until ACK is seen.
  - ACK = 1, START = 0: go to IDLE.
  - ACK = 1, START = 1 (same cycle): back-to-back restart. Load LOAD_VAL, then go to RUN, or stay in DONE if LOAD_VAL == 0.
  - ACK = 0: START is ignored.
- Latency: START accepted with LOAD_VAL = N > 0 and HOLD = 0 throughout.
  - COUNT = N after the load edge.
  - DONE = 1 after the Nth following edge, i.e. N+1 edges after the START cycle.
  - Each HOLD cycle in RUN adds exactly one cycle.
  - LOAD_VAL = 0 gives DONE = 1 after the load edge itself.
- Width and arithmetic:
  - Unsigned, modulo-free. COUNT never decrements below 0, so there is no wrap.
  - LOAD_VAL = 2^WIDTH-1 is legal and takes 2^WIDTH-1 decrement edges.
- Z invariant: Z updates on the same edge as COUNT, so Z == (COUNT == 0) holds in every cycle.
- BUSY and DONE are never high together. In IDLE both are 0.

Test Plan:
- Reset behaviour: assert RST mid-cycle with no clock edge -> COUNT = 0, Z = 1, BUSY = 0, DONE = 0 immediately. Assert RST during RUN at COUNT = 5 -> same values, and DONE never rises.
- Basic count: START with LOAD_VAL = 3, HOLD = 0 ->
  - COUNT sequence 3, 2, 1, 0 on successive edges.
  - Z = 0, 0, 0, 1.
  - BUSY high for 3 cycles; DONE = 1 on the 4th edge after the START cycle.
  - DONE holds until ACK, then IDLE with DONE = 0.
- Zero load: START with LOAD_VAL = 0 -> after one edge DONE = 1, Z = 1, BUSY never asserted.
- HOLD insertion: LOAD_VAL = 4, HOLD = 1 for 2 cycles when COUNT = 2 -> COUNT stays 2 for 2 extra cycles; DONE arrives 2 cycles later than the no-hold case (edge 7 instead of 5).
- Restart and ignored inputs:
  - In DONE, ACK = 1 and START = 1 with LOAD_VAL = 2 -> next edge COUNT = 2, BUSY = 1, then DONE after 2 more edges.
  - START pulses during RUN -> no reload.
  - ACK during RUN -> no effect.
- Boundary: LOAD_VAL = 8'hFF -> DONE exactly 256 edges after the START cycle; COUNT never wraps past 0; Z = 1 only in the final state.

Source files
------------

// File: rtl/zero_countdown_gen.sv
// Loadable down-counter with a registered zero flag and a DONE/ACK handshake.
// Drives COUNT toward zero for loop and delay timing beside the datapath.
module zero_countdown_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             HOLD,
  input  logic             ACK,
  output logic [WIDTH-1:0] COUNT,
  output logic             Z,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic             z_q, busy_q, done_q;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      ST_IDLE: begin
        if (START) begin
          count_nxt = LOAD_VAL;
          state_nxt = (LOAD_VAL == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // A zero count in RUN cannot arise; treating it as finished keeps COUNT from wrapping.
        if (count == '0) begin
          state_nxt = ST_DONE;
        end else if (!HOLD) begin
          count_nxt = count - ONE;
          if (count == ONE) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        count_nxt = '0;
        if (ACK) begin
          if (START) begin
            count_nxt = LOAD_VAL;
            state_nxt = (LOAD_VAL == '0) ? ST_DONE : ST_RUN;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // Flags are registered from the next-state values so they move on the same edge as COUNT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      count  <= '0;
      z_q    <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      z_q    <= (count_nxt == '0);
      busy_q <= (state_nxt == ST_RUN);
      done_q <= (state_nxt == ST_DONE);
    end
  end

  assign COUNT = count;
  assign Z     = z_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_zero_countdown_gen.sv
// Scoreboard bench for zero_countdown_gen: directed vectors queue expected
// outputs per edge, a monitor pops and compares one entry after each edge.
module tb_zero_countdown_gen;

  localparam int unsigned WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic [WIDTH-1:0] LOAD_VAL;
  logic             HOLD;
  logic             ACK;
  logic [WIDTH-1:0] COUNT;
  logic             Z;
  logic             BUSY;
  logic             DONE;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             z;
    logic             busy;
    logic             done;
    int               id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  zero_countdown_gen #(.WIDTH(WIDTH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .LOAD_VAL (LOAD_VAL),
    .HOLD     (HOLD),
    .ACK      (ACK),
    .COUNT    (COUNT),
    .Z        (Z),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic compare(input string name, input exp_t e);
    checks++;
    if (COUNT !== e.count || Z !== e.z || BUSY !== e.busy || DONE !== e.done) begin
      errors++;
      $display("FAIL %s step %0d: got count=%0d z=%b busy=%b done=%b, expected count=%0d z=%b busy=%b done=%b",
               name, e.id, COUNT, Z, BUSY, DONE, e.count, e.z, e.busy, e.done);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("edge", e);
      end
    end
  end

  // Drive inputs on the falling edge, queue the expected post-edge outputs.
  task automatic step(input logic st, input logic [WIDTH-1:0] lv, input logic hd,
                      input logic ak, input logic [WIDTH-1:0] ec,
                      input logic eb, input logic ed);
    exp_t e;
    @(negedge CLK);
    START = st; LOAD_VAL = lv; HOLD = hd; ACK = ak;
    e.count = ec; e.z = (ec == 0); e.busy = eb; e.done = ed; e.id = step_id;
    step_id++;
    exp_q.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  task automatic check_reset_now(input string name);
    exp_t e;
    e.count = '0; e.z = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.id = step_id;
    compare(name, e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; START = 1'b0; LOAD_VAL = '0; HOLD = 1'b0; ACK = 1'b0;
    #3;
    check_reset_now("reset_initial");
    @(negedge CLK);
    RST = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);

    // Basic count from 3, ignored START while in DONE, then ACK.
    step(1, 3, 0, 0, 3, 1, 0);
    step(0, 0, 0, 0, 2, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 5, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Zero load goes straight to DONE.
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0);

    // Load 4 with two HOLD cycles at COUNT=2; START/ACK during RUN ignored.
    step(1, 4, 0, 0, 4, 1, 0);
    step(0, 0, 0, 0, 3, 1, 0);
    step(0, 0, 0, 0, 2, 1, 0);
    step(0, 0, 1, 0, 2, 1, 0);
    step(1, 7, 1, 1, 2, 1, 0);
    step(1, 9, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Back-to-back restart from DONE, then restart with zero.
    step(1, 2, 0, 1, 2, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0);

    // Full-range load: DONE on the 256th edge, no wrap afterwards.
    step(1, 8'hFF, 0, 0, 8'hFF, 1, 0);
    for (int i = 254; i >= 1; i--) begin
      step(0, 0, 0, 0, WIDTH'(i), 1, 0);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0);

    // Asynchronous reset while running at COUNT=5.
    step(1, 10, 0, 0, 10, 1, 0);
    for (int i = 9; i >= 5; i--) begin
      step(0, 0, 0, 0, WIDTH'(i), 1, 0);
    end
    RST = 1'b1;
    #1;
    check_reset_now("reset_mid_run");
    step(1, 3, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset while in DONE.
    step(1, 1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    RST = 1'b1;
    #1;
    check_reset_now("reset_in_done");
    @(negedge CLK);
    RST = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
